// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU layer sequencer and its window address expander.
package npu_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} npu_state_e;

  localparam int NPU_TAPS      = 9;
  localparam int NPU_LANE_W    = 8;
  localparam int CFG_COLS_MIN  = 3;
  localparam int CFG_STEPS_MIN = 1;
  localparam int CFG_STEPS_MAX = 8;
endpackage

// File: rtl/npu_window_addr.sv
// Combinational expansion of an output pixel (oh, ow) into the nine packed 3x3 tap addresses.
module npu_window_addr
  import npu_pkg::*;
#(
  parameter int WB = 7,
  parameter int HB = 3
) (
  input  logic [HB-1:0]          oh_i,
  input  logic [WB-1:0]          ow_i,
  output logic [WB*NPU_TAPS-1:0] readi_w_o,
  output logic [HB*NPU_TAPS-1:0] readi_h_o
);
  always_comb begin
    readi_w_o = '0;
    readi_h_o = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        readi_w_o[(3*i+j)*WB +: WB] = ow_i + WB'(j);
        readi_h_o[(3*i+j)*HB +: HB] = oh_i + HB'(i);
      end
    end
  end
endmodule

// File: rtl/npu_sequencer.sv
// Layer control FSM: loads one feature-map tile, issues every 3x3 window read per step, drains, pulses done.
// Optional busy-cycle counter is built only when NPU_SEQ_PERF_EN is defined.
module npu_sequencer
  import npu_pkg::*;
#(
  parameter int width        = 80,
  parameter int height       = 8,
  parameter int width_b      = 7,
  parameter int height_b     = 3,
  parameter int DRAIN_CYCLES = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [width_b-1:0]             cfg_cols,
  input  logic [3:0]                     cfg_steps,
  input  logic [2:0]                     cfg_bound,
  input  logic                           cfg_relu,
  input  logic                           cfg_mp,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [NPU_TAPS*NPU_LANE_W-1:0] ld_data,
  output logic [width_b-1:0]             write_w,
  output logic [height_b-1:0]            write_h,
  output logic [NPU_TAPS*NPU_LANE_W-1:0] data_in,
  output logic [NPU_TAPS-1:0]            en_in,
  output logic [width_b*NPU_TAPS-1:0]    readi_w,
  output logic [height_b*NPU_TAPS-1:0]   readi_h,
  output logic [NPU_TAPS-1:0]            en_read,
  output logic                           en_bias,
  output logic [2:0]                     step,
  output logic [2:0]                     step_p,
  output logic                           en_pe,
  output logic [2:0]                     bound_level,
  output logic                           en_relu,
  output logic                           en_mp,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [31:0]                    perf_cycles
);
  npu_state_e                     state_q;
  logic [width_b-1:0]             cols_q, col_q, ow_q, write_w_q;
  logic [height_b-1:0]            row_q, oh_q, write_h_q;
  logic [3:0]                     steps_q;
  logic [2:0]                     s_q, step_q, bound_q, bound_level_q;
  logic                           relu_q, mp_q, fin_q;
  logic [7:0]                     drain_q;
  logic [NPU_TAPS*NPU_LANE_W-1:0] data_in_q;
  logic [NPU_TAPS-1:0]            en_in_q, en_read_q;
  logic [width_b*NPU_TAPS-1:0]    readi_w_q, win_w;
  logic [height_b*NPU_TAPS-1:0]   readi_h_q, win_h;
  logic ld_ready_q, en_bias_q, en_pe_q, en_relu_q, en_mp_q, busy_q, done_q, err_q;
  logic cfg_legal, row_last, col_last, s_last, ow_last, oh_last, drain_last;

  assign cfg_legal  = (cfg_cols >= width_b'(CFG_COLS_MIN)) && (cfg_cols <= width_b'(width)) &&
                      (cfg_steps >= 4'(CFG_STEPS_MIN)) && (cfg_steps <= 4'(CFG_STEPS_MAX));
  assign row_last   = (row_q == height_b'(height - 1));
  assign col_last   = (col_q == cols_q - width_b'(1));
  assign s_last     = ({1'b0, s_q} == steps_q - 4'd1);
  assign ow_last    = (ow_q == cols_q - width_b'(3));
  assign oh_last    = (oh_q == height_b'(height - 3));
  assign drain_last = (drain_q == 8'(DRAIN_CYCLES - 1));

  npu_window_addr #(.WB(width_b), .HB(height_b)) u_win (
    .oh_i(oh_q), .ow_i(ow_q), .readi_w_o(win_w), .readi_h_o(win_h)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      {cols_q, col_q, ow_q, write_w_q} <= '0;
      {row_q, oh_q, write_h_q} <= '0;
      {steps_q, s_q, step_q, bound_q, bound_level_q} <= '0;
      {relu_q, mp_q, fin_q, drain_q} <= '0;
      {data_in_q, en_in_q, en_read_q, readi_w_q, readi_h_q} <= '0;
      {ld_ready_q, en_bias_q, en_pe_q, en_relu_q, en_mp_q, busy_q, done_q, err_q} <= '0;
    end else begin
      // Pulse-style outputs fall back to zero unless this cycle's state drives them.
      en_in_q   <= '0;
      en_read_q <= '0;
      en_pe_q   <= 1'b0;
      en_bias_q <= 1'b0;
      step_q    <= '0;
      readi_w_q <= '0;
      readi_h_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      if (abort) begin
        state_q       <= IDLE;
        ld_ready_q    <= 1'b0;
        busy_q        <= 1'b0;
        fin_q         <= 1'b0;
        bound_level_q <= '0;
        en_relu_q     <= 1'b0;
        en_mp_q       <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start && cfg_legal) begin
              cols_q     <= cfg_cols;
              steps_q    <= cfg_steps;
              bound_q    <= cfg_bound;
              relu_q     <= cfg_relu;
              mp_q       <= cfg_mp;
              {row_q, col_q, oh_q, ow_q, s_q, fin_q} <= '0;
              ld_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= LOAD;
            end else if (start) begin
              err_q <= 1'b1;
            end
          end
          LOAD: begin
            if (ld_valid) begin
              write_w_q <= col_q;
              write_h_q <= row_q;
              data_in_q <= ld_data;
              en_in_q   <= '1;
              if (row_last) begin
                row_q <= '0;
                if (col_last) begin
                  ld_ready_q    <= 1'b0;
                  bound_level_q <= bound_q;
                  en_relu_q     <= relu_q;
                  en_mp_q       <= mp_q;
                  state_q       <= COMPUTE;
                end else begin
                  col_q <= col_q + width_b'(1);
                end
              end else begin
                row_q <= row_q + height_b'(1);
              end
            end
          end
          COMPUTE: begin
            // fin_q marks the cycle the final issue is on the outputs; leave only after it.
            if (fin_q) begin
              fin_q   <= 1'b0;
              drain_q <= '0;
              state_q <= DRAIN;
            end else begin
              en_read_q <= '1;
              en_pe_q   <= 1'b1;
              en_bias_q <= (s_q == 3'd0);
              step_q    <= s_q;
              readi_w_q <= win_w;
              readi_h_q <= win_h;
              if (s_last) begin
                s_q <= '0;
                if (ow_last) begin
                  ow_q <= '0;
                  if (oh_last) fin_q <= 1'b1;
                  else         oh_q  <= oh_q + height_b'(1);
                end else begin
                  ow_q <= ow_q + width_b'(1);
                end
              end else begin
                s_q <= s_q + 3'd1;
              end
            end
          end
          DRAIN: begin
            if (drain_last) begin
              done_q        <= 1'b1;
              bound_level_q <= '0;
              en_relu_q     <= 1'b0;
              en_mp_q       <= 1'b0;
              state_q       <= DONE;
            end else begin
              drain_q <= drain_q + 8'd1;
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef NPU_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        start_ok;

  assign start_ok = (state_q == IDLE) && start && !abort && cfg_legal;

  always_comb begin
    perf_d = perf_q;
    if (start_ok)                            perf_d = '0;
    else if (busy_q && (perf_q != '1))       perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  assign ld_ready    = ld_ready_q;
  assign write_w     = write_w_q;
  assign write_h     = write_h_q;
  assign data_in     = data_in_q;
  assign en_in       = en_in_q;
  assign readi_w     = readi_w_q;
  assign readi_h     = readi_h_q;
  assign en_read     = en_read_q;
  assign en_bias     = en_bias_q;
  assign step        = step_q;
  assign step_p      = step_q;
  assign en_pe       = en_pe_q;
  assign bound_level = bound_level_q;
  assign en_relu     = en_relu_q;
  assign en_mp       = en_mp_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
endmodule

// File: tb/tb_npu_sequencer.sv
// Randomized bench for npu_sequencer with a pixel/issue-order reference model.
`timescale 1ns/1ps
module tb_npu_sequencer;
  localparam int W = 80, H = 8, WB = 7, HB = 3, DR = 6;

  logic          clk = 1'b0;
  logic          reset, start, abort, cfg_relu, cfg_mp, ld_valid;
  logic [WB-1:0] cfg_cols;
  logic [3:0]    cfg_steps;
  logic [2:0]    cfg_bound;
  logic [71:0]   ld_data;
  logic          ld_ready, en_bias, en_pe, en_relu, en_mp, busy, done, err;
  logic [WB-1:0] write_w;
  logic [HB-1:0] write_h;
  logic [71:0]   data_in;
  logic [8:0]    en_in, en_read;
  logic [WB*9-1:0] readi_w;
  logic [HB*9-1:0] readi_h;
  logic [2:0]    step, step_p, bound_level;
  logic [31:0]   perf_cycles;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  npu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_cols(cfg_cols), .cfg_steps(cfg_steps), .cfg_bound(cfg_bound),
    .cfg_relu(cfg_relu), .cfg_mp(cfg_mp), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .write_w(write_w), .write_h(write_h), .data_in(data_in),
    .en_in(en_in), .readi_w(readi_w), .readi_h(readi_h), .en_read(en_read),
    .en_bias(en_bias), .step(step), .step_p(step_p), .en_pe(en_pe),
    .bound_level(bound_level), .en_relu(en_relu), .en_mp(en_mp), .busy(busy),
    .done(done), .err(err), .perf_cycles(perf_cycles)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    logic [511:0] all_out;
    reset = 1'b0; start = 0; abort = 0; ld_valid = 0; ld_data = '0;
    cfg_cols = '0; cfg_steps = '0; cfg_bound = '0; cfg_relu = 0; cfg_mp = 0;
    repeat (3) @(negedge clk);
    all_out = 512'({ld_ready, write_w, write_h, data_in, en_in, readi_w, readi_h, en_read, en_bias,
                    step, step_p, en_pe, bound_level, en_relu, en_mp, busy, done, err, perf_cycles});
    tests++;
    if (all_out !== '0) begin fails++; $display("FAIL reset_outputs: got %0h want 0", all_out); end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || ld_ready !== 1'b0) begin
      fails++; $display("FAIL reset_release: busy=%b ld_ready=%b want 0 0", busy, ld_ready);
    end
  endtask

  task automatic test_illegal_start();
    int cc, ss;
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: begin cc = 2; ss = 2; end
        1: begin cc = 4; ss = 0; end
        2: begin cc = $urandom_range(81, 127); ss = $urandom_range(1, 8); end
        default: begin cc = $urandom_range(3, 80); ss = $urandom_range(9, 15); end
      endcase
      cfg_cols = WB'(cc); cfg_steps = 4'(ss); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (err !== 1'b1 || busy !== 1'b0 || ld_ready !== 1'b0) begin
        fails++; $display("FAIL illegal_start_%0d: err=%b busy=%b ld_ready=%b want 1 0 0", t, err, busy, ld_ready);
      end
      @(negedge clk);
      tests++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL illegal_pulse_%0d: err=%b busy=%b want 0 0", t, err, busy);
      end
    end
  endtask

  // Runs one full layer and checks every write, issue, the done timing and the perf count.
  task automatic run_layer(input int cols, input int steps, input bit hold_valid, input string tag);
    logic [71:0] data [];
    logic [WB*9-1:0] exp_w;
    logic [HB*9-1:0] exp_h;
    logic [2:0] bnd;
    bit relu, mp, finished;
    int nb, ni, beat, wr, iss, busy_cnt, last_wr, last_iss, done_cyc, s, ow, oh;
    longint exp_perf;
    nb = cols * H; ni = (H - 2) * (cols - 2) * steps;
    beat = 0; wr = 0; iss = 0; busy_cnt = 0; last_wr = -10; last_iss = -10; done_cyc = -1;
    finished = 0;
    data = new[nb];
    foreach (data[i]) data[i] = 72'({$urandom(), $urandom(), $urandom()});
    bnd = 3'($urandom); relu = 1'($urandom); mp = 1'($urandom);
    @(negedge clk);
    cfg_cols = WB'(cols); cfg_steps = 4'(steps); cfg_bound = bnd; cfg_relu = relu; cfg_mp = mp;
    start = 1'b1; ld_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (done_cyc >= 0) begin
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          fails++; $display("FAIL %s busy_after_done: busy=%b done=%b want 0 0", tag, busy, done);
        end
        finished = 1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      tests++;
      if (ld_ready !== (beat < nb) || err !== 1'b0) begin
        fails++; $display("FAIL %s ld_ready cyc %0d: ld_ready=%b err=%b want %b 0", tag, cyc, ld_ready, err, beat < nb);
      end
      if (en_in !== 9'h0) begin
        tests++;
        if (wr >= nb || en_in !== 9'h1FF || write_w !== WB'(wr / H) || write_h !== HB'(wr % H) ||
            data_in !== data[wr]) begin
          fails++; $display("FAIL %s write %0d: en=%h w=%0d h=%0d want en=1ff w=%0d h=%0d", tag, wr,
                            en_in, write_w, write_h, wr / H, wr % H);
        end
        last_wr = cyc; wr++;
      end
      if (en_pe !== 1'b0 || en_read !== 9'h0) begin
        s = iss % steps; ow = (iss / steps) % (cols - 2); oh = iss / (steps * (cols - 2));
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            exp_w[(3*i+j)*WB +: WB] = WB'(ow + j);
            exp_h[(3*i+j)*HB +: HB] = HB'(oh + i);
          end
        tests++;
        if (iss >= ni || cyc !== (iss == 0 ? last_wr + 1 : last_iss + 1)) begin
          fails++; $display("FAIL %s issue_timing %0d: cyc=%0d last_wr=%0d last_iss=%0d", tag, iss, cyc, last_wr, last_iss);
        end
        tests++;
        if (en_pe !== 1'b1 || en_read !== 9'h1FF || en_bias !== (s == 0) || step !== 3'(s) ||
            step_p !== 3'(s) || readi_w !== exp_w || readi_h !== exp_h) begin
          fails++; $display("FAIL %s issue %0d: bias=%b step=%0d w=%h h=%h want bias=%b step=%0d w=%h h=%h",
                            tag, iss, en_bias, step, readi_w, readi_h, s == 0, s, exp_w, exp_h);
        end
        tests++;
        if (bound_level !== bnd || en_relu !== relu || en_mp !== mp) begin
          fails++; $display("FAIL %s issue_cfg %0d: bound=%0d relu=%b mp=%b want %0d %b %b", tag, iss,
                            bound_level, en_relu, en_mp, bnd, relu, mp);
        end
        last_iss = cyc; iss++;
      end else begin
        tests++;
        if (en_bias !== 1'b0) begin fails++; $display("FAIL %s bias_idle: got %b want 0", tag, en_bias); end
      end
      if (done === 1'b1) begin
        tests++;
        if (iss !== ni || wr !== nb || cyc !== last_iss + DR + 1) begin
          fails++; $display("FAIL %s done: iss=%0d wr=%0d cyc=%0d want iss=%0d wr=%0d cyc=%0d", tag, iss, wr,
                            cyc, ni, nb, last_iss + DR + 1);
        end
        done_cyc = cyc;
      end
      // Config and stray start pulses while busy must have no effect.
      cfg_cols = WB'($urandom); cfg_steps = 4'($urandom); cfg_bound = 3'($urandom);
      cfg_relu = 1'($urandom); cfg_mp = 1'($urandom);
      start = ($urandom_range(0, 7) == 0);
      ld_data = 72'({$urandom(), $urandom(), $urandom()});
      if (ld_ready === 1'b1 && beat < nb) begin
        ld_valid = hold_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
        ld_data = data[beat];
        if (ld_valid) beat++;
      end else begin
        ld_valid = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0; ld_valid = 1'b0;
    if (!finished) begin
      tests++; fails++;
      $display("FAIL %s timeout: done not seen, iss=%0d wr=%0d", tag, iss, wr);
    end
`ifdef NPU_SEQ_PERF_EN
    exp_perf = busy_cnt;
`else
    exp_perf = 0;
`endif
    tests++;
    if (perf_cycles !== 32'(exp_perf)) begin
      fails++; $display("FAIL %s perf: got %0d want %0d", tag, perf_cycles, exp_perf);
    end
  endtask

  task automatic test_load_compute();
    run_layer(4, 2, 1'b1, "dir_c4_s2");
  endtask

  task automatic start_run(input int cols, input int steps);
    @(negedge clk);
    cfg_cols = WB'(cols); cfg_steps = 4'(steps); cfg_bound = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    ld_valid = 1'b1;
    while (en_pe !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    ld_valid = 1'b0;
    tests++;
    if (en_pe !== 1'b1) begin fails++; $display("FAIL %s wait_issue: en_pe=%b want 1", tag, en_pe); end
  endtask

  task automatic test_abort();
    start_run(5, 3);
    wait_issue("abort");
    repeat ($urandom_range(0, 5)) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (busy !== 0 || en_pe !== 0 || en_read !== 9'h0 || done !== 0 || bound_level !== 3'd0) begin
      fails++; $display("FAIL abort_compute: busy=%b en_pe=%b en_read=%h done=%b bound=%0d want all 0",
                        busy, en_pe, en_read, done, bound_level);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL abort_quiet %0d: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    start_run(4, 1);
    ld_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    tests++;
    if (en_in !== 9'h0 || busy !== 1'b0 || ld_ready !== 1'b0) begin
      fails++; $display("FAIL abort_beat: en_in=%h busy=%b ld_ready=%b want 0 0 0", en_in, busy, ld_ready);
    end
  endtask

  task automatic test_reset_mid();
    start_run(6, 4);
    wait_issue("reset_mid");
    #2 reset = 1'b0;
    #1;
    tests++;
    if (busy !== 0 || en_pe !== 0 || en_read !== 9'h0 || ld_ready !== 0 || perf_cycles !== 32'd0) begin
      fails++; $display("FAIL reset_mid: busy=%b en_pe=%b en_read=%h ld_ready=%b perf=%0d want all 0",
                        busy, en_pe, en_read, ld_ready, perf_cycles);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_mid_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++)
      run_layer($urandom_range(3, 10), $urandom_range(1, 8), 1'b0, $sformatf("rand%0d", r));
    run_layer(3, 1, 1'b0, "min_c3_s1");
    run_layer(W, 1, 1'b1, "max_cols");
  endtask

  initial begin
    test_reset();
    test_illegal_start();
    test_load_compute();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/npu_sequencer.md
# npu_sequencer

Layer-level control FSM driving the NPU top's control inputs for one 3x3 convolution tile. It accepts a layer configuration and a streamed feature-map tile from the host, writes the tile into feature-map memory, then issues one 3x3 window read per output pixel per step. After the last issue it waits a fixed drain time and signals completion. It sits between the host/DMA interface and the NPU top, owning every write/read/enable input of that top.

## Interface
- `width`, 80: feature-map memory columns.
- `height`, 8: feature-map memory rows.
- `width_b`, 7: column address bits.
- `height_b`, 3: row address bits.
- `DRAIN_CYCLES`, 6: cycles from last issue to `done`; range 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: request a layer run; sampled in IDLE only.
- `abort` in 1: synchronous return to IDLE.
- `cfg_cols` in width_b: tile columns, legal 3..width.
- `cfg_steps` in 4: steps per pixel, legal 1..8.
- `cfg_bound` in 3: bound level for the NPU.
- `cfg_relu` in 1: ReLU enable for the NPU.
- `cfg_mp` in 1: max-pool enable for the NPU.
- `ld_valid` in 1: load beat valid.
- `ld_ready` out 1: load beat accepted when high together with `ld_valid`.
- `ld_data` in 72: nine 8-bit channel values for one pixel.
- `write_w` out width_b: write column.
- `write_h` out height_b: write row.
- `data_in` out 72: write data.
- `en_in` out 9: write enables.
- `readi_w` out width_b*9: read column addresses, one per tap.
- `readi_h` out height_b*9: read row addresses, one per tap.
- `en_read` out 9: read enables.
- `en_bias` out 1: bias load.
- `step` out 3: current step.
- `step_p` out 3: current step.
- `en_pe` out 1: PE enable.
- `bound_level` out 3: latched bound level.
- `en_relu` out 1: ReLU enable.
- `en_mp` out 1: max-pool enable.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse on an illegal `start`.
- `perf_cycles` out 32: busy-cycle count.

## Operation
- States and transitions:
  - IDLE -> LOAD on `start` with legal config. Config is latched on this cycle.
  - `start` with illegal config: `err` pulses, FSM stays in IDLE.
  - LOAD -> COMPUTE after `cfg_cols*height` accepted beats.
  - COMPUTE -> DRAIN after the last issue.
  - DRAIN -> DONE after `DRAIN_CYCLES` cycles.
  - DONE -> IDLE after one cycle.
- LOAD:
  - `ld_ready`=1 throughout the state.
  - Beats are column-major: row 0..height-1 inner, column 0..cfg_cols-1 outer.
  - For an accepted beat, the next cycle carries `write_w`=col, `write_h`=row, `data_in`=`ld_data`, `en_in`=9'h1FF.
  - `en_in`=0 in every other cycle.
- COMPUTE loop order: output row oh 0..height-3 (outermost), output column ow 0..cfg_cols-3, step s 0..cfg_steps-1 (innermost). One issue per cycle, no stalls.
- Per issue, tap k=3i+j (i,j in 0..2):
  - `readi_w[k*width_b+:width_b]`=ow+j.
  - `readi_h[k*height_b+:height_b]`=oh+i.
- Per issue enables and step:
  - `en_read`=9'h1FF, `en_pe`=1.
  - `en_bias`=1 only when s==0.
  - `step`=`step_p`=s[2:0].
- Issue count is `(height-2)*(cfg_cols-2)*cfg_steps`.
- `bound_level`, `en_relu`, `en_mp` drive latched config during COMPUTE and DRAIN; 0 otherwise.
- `abort` has priority over every transition. Next cycle: IDLE, all enables 0, no `done`.
- `start` outside IDLE is ignored.

## Timing
- All outputs are registered.
- Reset value of every output is 0, except `ld_ready`, which is also 0.
- `ld_ready` rises the cycle after `start` is accepted.
- First issue is the cycle after the last load write.
- `done` is asserted in DONE. `busy` falls the cycle after `done`.
- Reset asserted mid-run: immediate IDLE, outputs 0, counters cleared.
- Beat and `abort` in the same cycle: the beat is dropped and no write is issued.

## Configuration
- `NPU_SEQ_PERF_EN` defined:
  - `perf_cycles` increments every cycle `busy`=1 and saturates at 32'hFFFFFFFF.
  - Cleared on accepted `start` and on reset.
- `NPU_SEQ_PERF_EN` undefined: `perf_cycles` is tied to 0 and no counter logic is built.

## Structure
- Shared package `npu_pkg`:
  - State enum (IDLE, LOAD, COMPUTE, DRAIN, DONE).
  - Tap count constant 9.
  - Lane width constant 8.
  - Legal-range constants for `cfg_cols` and `cfg_steps`.
- One sub-module `npu_window_addr`: combinational expansion of (oh, ow) into packed `readi_w`/`readi_h`.

## Test plan
- Illegal `start`:
  - `cfg_cols`=2 -> `err` one cycle, `busy` stays 0.
  - `cfg_steps`=0 -> `err` one cycle, `busy` stays 0.
- Load, `cfg_cols`=4, `ld_valid` held high:
  - 32 writes; beat 9 writes `write_w`=1, `write_h`=0.
  - `en_in`=9'h1FF on each write.
  - COMPUTE entered after beat 32.
- Compute, `cfg_cols`=4, `cfg_steps`=2 -> 24 issues.
  - Issue 0: oh=0, ow=0, s=0, `en_bias`=1.
  - Issue 3: ow=1, s=1, `en_bias`=0.
  - Tap 8 of issue 3: col 3, row 2.
- Drain and done:
  - `done` exactly 7 cycles after the last issue (6 drain cycles + DONE).
  - `busy` low the cycle after `done`.
- Abort mid-COMPUTE -> next cycle: IDLE, `en_pe`=0, `en_read`=0, no `done`.
- Perf counter with `NPU_SEQ_PERF_EN` defined:
  - `perf_cycles` equals total busy cycles of one run.
  - With the macro undefined it reads 0.
